dsp_mult_mreg: RTL and testbench

- Signed 25x18 multiplier stage directly downstream of the dual A/D pre-adder register stage.
- Consumes the 25-bit AD/A multiplier operand and the 18-bit B multiplier operand.
- Produces two 43-bit partial products for the X and Y muxes, plus a sign flag, through the optional M pipeline register.
- Partial products come from a radix-4 Booth array compressed to two vectors; the downstream ALU adds them.

---
 rtl/dsp_mult_mreg_if.sv | 21 ++
 rtl/dsp_mult_mreg.sv | 162 ++++++++++++++++
 tb/tb_dsp_mult_mreg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dsp_mult_mreg_if.sv
// Operand/product bundle between the pre-adder stage and the M stage.
// The master drives operands and the M-stage enable; the slave returns the partial products.
interface dsp_mult_mreg_if;
  logic        CEM;
  logic [24:0] a_mult;
  logic [17:0] b_mult;
  logic [42:0] pp_x;
  logic [42:0] pp_y;
  logic        mult_sign;
  logic        m_valid;

  modport master (
    output CEM, a_mult, b_mult,
    input  pp_x, pp_y, mult_sign, m_valid
  );

  modport slave (
    input  CEM, a_mult, b_mult,
    output pp_x, pp_y, mult_sign, m_valid
  );
endinterface

// File: rtl/dsp_mult_mreg.sv
// Signed 25x18 radix-4 Booth multiplier producing two 43-bit partial products, with optional M register.
// Defining DSP_MULT_PIPE2_EN (MREG=1 only) splits the CSA tree across two register ranks.
module dsp_mult_mreg #(
  parameter int    MREG     = 1,
  parameter string USE_MULT = "MULTIPLY",
  parameter int    PP_W     = 43
) (
  input  logic           clk,
  input  logic           RSTM,
  dsp_mult_mreg_if.slave mif
);

  localparam bit MULT_ON = (USE_MULT != "NONE");

  function automatic logic [PP_W-1:0] csa_sum(input logic [PP_W-1:0] x, input logic [PP_W-1:0] y,
                                              input logic [PP_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  // Carries past the top bit fall off, which is exactly the mod-2^PP_W behaviour wanted.
  function automatic logic [PP_W-1:0] csa_carry(input logic [PP_W-1:0] x, input logic [PP_W-1:0] y,
                                                input logic [PP_W-1:0] z);
    logic [PP_W-1:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[PP_W-2:0], 1'b0};
  endfunction

  logic [3:0][PP_W-1:0] q_s;
  logic [3:0][PP_W-1:0] qb_s;
  logic [PP_W-1:0]      x0_s, y0_s, fx_s, fy_s, fsum_s;
  logic                 fsign_s;

  generate
    if (!MULT_ON) begin : g_off
      assign q_s = {(4*PP_W){1'b0}};
    end else begin : g_booth
      logic [PP_W-1:0]      a_ext_s, mag_s;
      logic [18:0]          b_ext_s;
      logic [2:0]           dig_s;
      logic                 neg_s;
      logic [9:0][PP_W-1:0] row_s;
      logic [6:0][PP_W-1:0] l1_s;
      logic [4:0][PP_W-1:0] l2_s;

      // Booth row generation and CSA reduction of ten vectors down to four.
      always_comb begin
        a_ext_s = {{(PP_W-25){mif.a_mult[24]}}, mif.a_mult};
        b_ext_s = {mif.b_mult, 1'b0};
        row_s   = {(10*PP_W){1'b0}};
        mag_s   = {PP_W{1'b0}};
        dig_s   = 3'd0;
        neg_s   = 1'b0;
        for (int i = 0; i < 9; i++) begin
          dig_s = b_ext_s[2*i +: 3];
          case (dig_s)
            3'b001, 3'b010: begin mag_s = a_ext_s;                       neg_s = 1'b0; end
            3'b011:         begin mag_s = {a_ext_s[PP_W-2:0], 1'b0};     neg_s = 1'b0; end
            3'b100:         begin mag_s = {a_ext_s[PP_W-2:0], 1'b0};     neg_s = 1'b1; end
            3'b101, 3'b110: begin mag_s = a_ext_s;                       neg_s = 1'b1; end
            default:        begin mag_s = {PP_W{1'b0}};                  neg_s = 1'b0; end
          endcase
          row_s[i]      = (neg_s ? ~mag_s : mag_s) << (2 * i);
          // Row 9 gathers the +1 of every negated row; the positions never overlap.
          row_s[9][2*i] = neg_s;
        end

        l1_s[0] = csa_sum  (row_s[0], row_s[1], row_s[2]);
        l1_s[1] = csa_carry(row_s[0], row_s[1], row_s[2]);
        l1_s[2] = csa_sum  (row_s[3], row_s[4], row_s[5]);
        l1_s[3] = csa_carry(row_s[3], row_s[4], row_s[5]);
        l1_s[4] = csa_sum  (row_s[6], row_s[7], row_s[8]);
        l1_s[5] = csa_carry(row_s[6], row_s[7], row_s[8]);
        l1_s[6] = row_s[9];

        l2_s[0] = csa_sum  (l1_s[0], l1_s[1], l1_s[2]);
        l2_s[1] = csa_carry(l1_s[0], l1_s[1], l1_s[2]);
        l2_s[2] = csa_sum  (l1_s[3], l1_s[4], l1_s[5]);
        l2_s[3] = csa_carry(l1_s[3], l1_s[4], l1_s[5]);
        l2_s[4] = l1_s[6];

        q_s[0] = csa_sum  (l2_s[0], l2_s[1], l2_s[2]);
        q_s[1] = csa_carry(l2_s[0], l2_s[1], l2_s[2]);
        q_s[2] = l2_s[3];
        q_s[3] = l2_s[4];
      end
    end
  endgenerate

  // Final two CSA levels plus the sign adder.
  always_comb begin
    x0_s    = csa_sum  (qb_s[0], qb_s[1], qb_s[2]);
    y0_s    = csa_carry(qb_s[0], qb_s[1], qb_s[2]);
    fx_s    = csa_sum  (x0_s, y0_s, qb_s[3]);
    fy_s    = csa_carry(x0_s, y0_s, qb_s[3]);
    fsum_s  = fx_s + fy_s;
    fsign_s = fsum_s[PP_W-1];
  end

  generate
    if (MREG == 0) begin : g_comb
      assign qb_s          = q_s;
      assign mif.pp_x      = fx_s;
      assign mif.pp_y      = fy_s;
      assign mif.mult_sign = fsign_s;
      assign mif.m_valid   = 1'b1;
    end else begin : g_reg
      logic [PP_W-1:0] pp_x_r, pp_y_r;
      logic            sign_r, m_valid_r;
      logic            cap_valid_s;
`ifdef DSP_MULT_PIPE2_EN
      logic [3:0][PP_W-1:0] q1_r;
      logic                 v1_r;

      // First rank: four-vector snapshot of the partially reduced Booth array.
      always_ff @(posedge clk) begin
        if (RSTM) begin
          q1_r <= {(4*PP_W){1'b0}};
          v1_r <= 1'b0;
        end else if (mif.CEM) begin
          q1_r <= q_s;
          v1_r <= 1'b1;
        end else begin
          q1_r <= q1_r;
          v1_r <= v1_r;
        end
      end

      assign qb_s        = q1_r;
      assign cap_valid_s = v1_r;
`else
      assign qb_s        = q_s;
      assign cap_valid_s = 1'b1;
`endif

      // Output rank: reset wins over enable; a disabled enable freezes everything.
      always_ff @(posedge clk) begin
        if (RSTM) begin
          pp_x_r    <= {PP_W{1'b0}};
          pp_y_r    <= {PP_W{1'b0}};
          sign_r    <= 1'b0;
          m_valid_r <= 1'b0;
        end else if (mif.CEM) begin
          pp_x_r    <= fx_s;
          pp_y_r    <= fy_s;
          sign_r    <= fsign_s;
          m_valid_r <= cap_valid_s;
        end else begin
          pp_x_r    <= pp_x_r;
          pp_y_r    <= pp_y_r;
          sign_r    <= sign_r;
          m_valid_r <= m_valid_r;
        end
      end

      assign mif.pp_x      = MULT_ON ? pp_x_r : {PP_W{1'b0}};
      assign mif.pp_y      = MULT_ON ? pp_y_r : {PP_W{1'b0}};
      assign mif.mult_sign = MULT_ON ? sign_r : 1'b0;
      assign mif.m_valid   = m_valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_dsp_mult_mreg.sv
// Scoreboard bench for dsp_mult_mreg: registered, combinational and powered-down instances
// driven with identical operands and checked against a plain-arithmetic product model.
module tb_dsp_mult_mreg;

`ifdef DSP_MULT_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rstm;
  always #5 clk = ~clk;

  dsp_mult_mreg_if m1_if ();
  dsp_mult_mreg_if m0_if ();
  dsp_mult_mreg_if nz_if ();

  dsp_mult_mreg #(.MREG(1), .USE_MULT("MULTIPLY")) u_m1 (.clk(clk), .RSTM(rstm), .mif(m1_if));
  dsp_mult_mreg #(.MREG(0), .USE_MULT("MULTIPLY")) u_m0 (.clk(clk), .RSTM(rstm), .mif(m0_if));
  dsp_mult_mreg #(.MREG(1), .USE_MULT("NONE"))     u_nz (.clk(clk), .RSTM(rstm), .mif(nz_if));

  typedef struct {
    logic [42:0] sum1;
    logic        valid1;
    logic [42:0] sum0;
  } exp_t;

  exp_t        sb_q[$];
  logic [42:0] hist[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  function automatic logic [42:0] ref_prod(input logic [24:0] a, input logic [17:0] b);
    longint      pa, pb, p;
    logic [63:0] pu;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    pu = p;
    return pu[42:0];
  endfunction

  task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  always @(posedge clk) begin
    exp_t        e;
    logic [42:0] s;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      s = m1_if.pp_x + m1_if.pp_y;
      check("m1_sum",   s, e.sum1);
      check("m1_sign",  43'(m1_if.mult_sign), 43'(e.sum1[42]));
      check("m1_valid", 43'(m1_if.m_valid), 43'(e.valid1));
      s = m0_if.pp_x + m0_if.pp_y;
      check("m0_sum",   s, e.sum0);
      check("m0_sign",  43'(m0_if.mult_sign), 43'(e.sum0[42]));
      check("m0_valid", 43'(m0_if.m_valid), 43'd1);
      check("nz_pp_x",  nz_if.pp_x, 43'd0);
      check("nz_pp_y",  nz_if.pp_y, 43'd0);
      check("nz_sign",  43'(nz_if.mult_sign), 43'd0);
      check("nz_valid", 43'(nz_if.m_valid), 43'(e.valid1));
    end
  end

  task automatic step(input logic rst, input logic cem, input logic [24:0] a, input logic [17:0] b);
    exp_t e;
    @(negedge clk);
    rstm = rst;
    m1_if.CEM = cem; m1_if.a_mult = a; m1_if.b_mult = b;
    m0_if.CEM = cem; m0_if.a_mult = a; m0_if.b_mult = b;
    nz_if.CEM = cem; nz_if.a_mult = a; nz_if.b_mult = b;
    // Model: the output shows the product captured LAT enabled edges ago.
    if (rst) hist.delete();
    else if (cem) begin
      hist.push_back(ref_prod(a, b));
      if (hist.size() > LAT) void'(hist.pop_front());
    end
    e.valid1 = (hist.size() == LAT);
    e.sum1   = e.valid1 ? hist[0] : 43'd0;
    e.sum0   = ref_prod(a, b);
    sb_q.push_back(e);
  endtask

  function automatic logic [24:0] rand_a();
    int m;
    m = $urandom_range(0, 7);
    case (m)
      0:       return 25'h1000000;
      1:       return 25'h0FFFFFF;
      2:       return 25'h1FFFFFF;
      default: return 25'($urandom());
    endcase
  endfunction

  function automatic logic [17:0] rand_b();
    int m;
    m = $urandom_range(0, 7);
    case (m)
      0:       return 18'h20000;
      1:       return 18'h1FFFF;
      2:       return 18'd0;
      default: return 18'($urandom());
    endcase
  endfunction

  initial begin
    rstm = 1'b1;
    m1_if.CEM = 1'b0; m1_if.a_mult = 25'd0; m1_if.b_mult = 18'd0;
    m0_if.CEM = 1'b0; m0_if.a_mult = 25'd0; m0_if.b_mult = 18'd0;
    nz_if.CEM = 1'b0; nz_if.a_mult = 25'd0; nz_if.b_mult = 18'd0;

    step(1'b1, 1'b0, 25'd0, 18'd0);
    step(1'b1, 1'b1, 25'd0, 18'd0);
    step(1'b0, 1'b1, 25'd3, 18'd5);
    step(1'b0, 1'b1, 25'h1FFFFFF, 18'd1);
    step(1'b0, 1'b1, 25'h1000000, 18'h20000);
    step(1'b0, 1'b1, 25'h1000000, 18'h1FFFF);
    step(1'b0, 1'b1, 25'd0, 18'h2ABCD);
    step(1'b0, 1'b1, 25'h0ABCDE, 18'd0);
    step(1'b0, 1'b1, 25'd7, 18'd9);
    step(1'b0, 1'b1, 25'd7, 18'd9);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, rand_a(), rand_b());
    step(1'b1, 1'b1, 25'd11, 18'd13);
    step(1'b0, 1'b0, 25'd1, 18'd1);

    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), rand_a(), rand_b());

    repeat (3) @(negedge clk);
    check("sb_drain", 43'(sb_q.size()), 43'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
